// File: rtl/mips_mem_stage.sv
// MIPS pipeline data-memory stage: size-formatted stores, combinational formatted loads.
// Define MEM_DEBUG_BUS_EN to drive o_bus_debug with the full memory image (zeros otherwise).
module mips_mem_stage #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_flush,
    input  logic                                    i_mem_wr_rd,
    input  logic [1:0]                              i_mem_wr_src,
    input  logic [2:0]                              i_mem_rd_src,
    input  logic [IO_BUS_SIZE-1:0]                  i_alu_res,
    input  logic [IO_BUS_SIZE-1:0]                  i_bus_b,
    output logic [IO_BUS_SIZE-1:0]                  o_mem_rd,
    output logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] o_bus_debug
);

    localparam int DEPTH = 2**MEM_ADDR_SIZE;

    logic [IO_BUS_SIZE-1:0]   mem [DEPTH];
    logic [MEM_ADDR_SIZE-1:0] addr;
    logic [IO_BUS_SIZE-1:0]   wr_data;
    logic [IO_BUS_SIZE-1:0]   rd_word;
    logic                     unused_addr_bits;

    // Upper address bits are deliberately dropped, so addresses wrap modulo DEPTH.
    assign addr             = i_alu_res[MEM_ADDR_SIZE-1:0];
    assign unused_addr_bits = ^i_alu_res[IO_BUS_SIZE-1:MEM_ADDR_SIZE];

    always_comb begin
        wr_data = i_bus_b;
        case (i_mem_wr_src)
            2'b01:   wr_data = {{(IO_BUS_SIZE-16){1'b0}}, i_bus_b[15:0]};
            2'b10:   wr_data = {{(IO_BUS_SIZE-8){1'b0}}, i_bus_b[7:0]};
            default: wr_data = i_bus_b;
        endcase
    end

    // NOTE: the whole array is reset because the debug bus and loads must read zero
    // immediately on reset; this forces flops rather than a RAM macro.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_mem_wr_rd) begin
            mem[addr] <= wr_data;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
    assign rd_word = mem[addr];

    always_comb begin
        o_mem_rd = rd_word;
        case (i_mem_rd_src)
            3'b001:  o_mem_rd = {{(IO_BUS_SIZE-16){rd_word[15]}}, rd_word[15:0]};
            3'b010:  o_mem_rd = {{(IO_BUS_SIZE-16){1'b0}}, rd_word[15:0]};
            3'b011:  o_mem_rd = {{(IO_BUS_SIZE-8){rd_word[7]}}, rd_word[7:0]};
            3'b100:  o_mem_rd = {{(IO_BUS_SIZE-8){1'b0}}, rd_word[7:0]};
            default: o_mem_rd = rd_word;
        endcase
    end

`ifdef MEM_DEBUG_BUS_EN
    for (genvar k = 0; k < DEPTH; k++) begin : g_debug
        assign o_bus_debug[k*IO_BUS_SIZE +: IO_BUS_SIZE] = mem[k];
    end
`else
    assign o_bus_debug = '0;
`endif

endmodule

// File: tb/tb_mips_mem_stage.sv
// Testbench for mips_mem_stage: directed test-plan steps plus random traffic
// checked against an array-based reference model.
module tb_mips_mem_stage;

    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_flush = 1'b0;
    logic              i_mem_wr_rd = 1'b0;
    logic [1:0]        i_mem_wr_src = 2'b00;
    logic [2:0]        i_mem_rd_src = 3'b000;
    logic [W-1:0]      i_alu_res = '0;
    logic [W-1:0]      i_bus_b = '0;
    logic [W-1:0]      o_mem_rd;
    logic [DEPTH*W-1:0] o_bus_debug;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] model [DEPTH];

    mips_mem_stage #(.IO_BUS_SIZE(W), .MEM_ADDR_SIZE(AW)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .i_mem_wr_rd  (i_mem_wr_rd),
        .i_mem_wr_src (i_mem_wr_src),
        .i_mem_rd_src (i_mem_rd_src),
        .i_alu_res    (i_alu_res),
        .i_bus_b      (i_bus_b),
        .o_mem_rd     (o_mem_rd),
        .o_bus_debug  (o_bus_debug)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [W-1:0] store_fmt(logic [1:0] src, logic [W-1:0] d);
        case (src)
            2'd1:    return d % 65536;
            2'd2:    return d % 256;
            default: return d;
        endcase
    endfunction

    function automatic logic [W-1:0] load_fmt(logic [2:0] src, logic [W-1:0] w);
        logic [W-1:0] h, b;
        h = w % 65536;
        b = w % 256;
        case (src)
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return h;
            3'd3:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            default: return w;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Combinational read at a given address/format; caller keeps away from the clock edge.
    task automatic read_check(input string tag, input logic [W-1:0] a, input logic [2:0] src);
        i_alu_res    = a;
        i_mem_rd_src = src;
        #1;
        check(tag, o_mem_rd, load_fmt(src, model[a % DEPTH]));
    endtask

    task automatic read_const(input string tag, input logic [W-1:0] a, input logic [2:0] src,
                              input logic [W-1:0] expected);
        i_alu_res    = a;
        i_mem_rd_src = src;
        #1;
        check(tag, o_mem_rd, expected);
    endtask

    // One write edge; also confirms the same-cycle read still returns the old word.
    task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d, input logic [1:0] src);
        @(negedge i_clk);
        i_alu_res    = a;
        i_bus_b      = d;
        i_mem_wr_src = src;
        i_mem_rd_src = 3'b000;
        i_mem_wr_rd  = 1'b1;
        #1;
        check("same_cycle_old", o_mem_rd, model[a % DEPTH]);
        @(posedge i_clk);
        #1;
        i_mem_wr_rd = 1'b0;
        model[a % DEPTH] = store_fmt(src, d);
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < DEPTH; k++) read_const(tag, k, 3'b000, '0);
`ifdef MEM_DEBUG_BUS_EN
        for (int k = 0; k < DEPTH; k++) check({tag, "_dbg"}, o_bus_debug[k*W +: W], '0);
`endif
    endtask

    task automatic check_debug(input string tag);
`ifdef MEM_DEBUG_BUS_EN
        for (int k = 0; k < DEPTH; k++) check(tag, o_bus_debug[k*W +: W], model[k]);
`else
        check(tag, o_bus_debug[W-1:0], '0);
        check(tag, o_bus_debug[DEPTH*W-1 -: W], '0);
`endif
    endtask

    initial begin
        logic [W-1:0] a, d;
        logic [1:0]   ws;
        logic [2:0]   rs;

        for (int k = 0; k < DEPTH; k++) model[k] = '0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #2;
        check_all_zero("reset_state");
        @(negedge i_clk);
        i_reset = 1'b0;

        // Store formats
        do_write(32'd3, 32'hDEAD_BEEF, 2'b00);
        do_write(32'd4, 32'hDEAD_BEEF, 2'b01);
        do_write(32'd5, 32'hDEAD_BEEF, 2'b10);
        do_write(32'd6, 32'hDEAD_BEEF, 2'b11);
        read_const("st_word",   32'd3, 3'b000, 32'hDEAD_BEEF);
        read_const("st_half",   32'd4, 3'b000, 32'h0000_BEEF);
        read_const("st_byte",   32'd5, 3'b000, 32'h0000_00EF);
        read_const("st_fmt11",  32'd6, 3'b000, 32'hDEAD_BEEF);

        // Load formats
        do_write(32'd7, 32'h1234_F08A, 2'b00);
        read_const("ld_shalf",  32'd7, 3'b001, 32'hFFFF_F08A);
        read_const("ld_uhalf",  32'd7, 3'b010, 32'h0000_F08A);
        read_const("ld_sbyte",  32'd7, 3'b011, 32'hFFFF_FF8A);
        read_const("ld_ubyte",  32'd7, 3'b100, 32'h0000_008A);
        read_const("ld_word",   32'd7, 3'b000, 32'h1234_F08A);
        read_const("ld_fmt111", 32'd7, 3'b111, 32'h1234_F08A);

        // Address wrap and no-write cycle
        do_write(32'h0000_0021, 32'hA5A5_A5A5, 2'b00);
        read_const("wrap", 32'd1, 3'b000, 32'hA5A5_A5A5);
        @(negedge i_clk);
        i_alu_res   = 32'd1;
        i_bus_b     = 32'h1111_1111;
        i_mem_wr_rd = 1'b0;
        @(posedge i_clk);
        #1;
        read_const("no_write", 32'd1, 3'b000, 32'hA5A5_A5A5);

        // Reset asserted mid-cycle during a pending write: write must not happen
        @(negedge i_clk);
        i_alu_res   = 32'd9;
        i_bus_b     = 32'h5555_AAAA;
        i_mem_wr_rd = 1'b1;
        #2;
        i_reset = 1'b1;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        #1;
        check_all_zero("reset_mid");
        @(posedge i_clk);
        #1;
        i_mem_wr_rd = 1'b0;
        read_const("reset_beats_write", 32'd9, 3'b000, '0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Flush vs write
        for (int k = 0; k < 20; k++) do_write(k, $urandom, 2'b00);
        read_check("fill_2", 32'd2, 3'b000);
        read_check("fill_19", 32'd19, 3'b000);
        @(negedge i_clk);
        i_flush     = 1'b1;
        i_mem_wr_rd = 1'b1;
        i_alu_res   = 32'd2;
        i_bus_b     = 32'hCAFE_F00D;
        @(posedge i_clk);
        #1;
        i_flush     = 1'b0;
        i_mem_wr_rd = 1'b0;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        check_all_zero("flush");

        // Debug bus image
        for (int k = 0; k < DEPTH; k++) do_write(k, k + 1, 2'b00);
        check_debug("debug_bus");

        // Random traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            a  = $urandom;
            d  = $urandom;
            ws = 2'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) begin
                @(negedge i_clk);
                i_flush     = 1'b1;
                i_mem_wr_rd = 1'($urandom_range(0, 1));
                i_alu_res   = a;
                @(posedge i_clk);
                #1;
                i_flush     = 1'b0;
                i_mem_wr_rd = 1'b0;
                for (int k = 0; k < DEPTH; k++) model[k] = '0;
            end else if ($urandom_range(0, 3) != 0) begin
                do_write(a, d, ws);
            end else begin
                @(negedge i_clk);
            end
            read_check("rand_rd", $urandom, rs);
            read_check("rand_rd_same", a, rs);
        end
        check_debug("rand_debug");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
